// File: rtl/vector_dense_layer_if.sv
// rtl/vector_dense_layer_if.sv - start/operand/result/weight-memory bus of vector_dense_layer
//
// Signals:
//   start        request pulse, ignored while busy
//   data_in      x vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bias_in      b vector, same packing
//   weight_rd    weight memory read enable
//   weight_addr  weight memory address, row*INPUT_COUNT + col
//   weight_data  weight returned one cycle after the read
//   data_out     y vector, same packing
//   busy         layer is computing
//   done         one-cycle completion pulse
// Modports: master = requester plus weight memory, slave = the layer.
interface vector_dense_layer_if #(
    parameter int INPUT_COUNT  = 64,
    parameter int OUTPUT_COUNT = 128,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 13
);
    logic                               start;
    logic [DATA_WIDTH*INPUT_COUNT-1:0]  data_in;
    logic [DATA_WIDTH*OUTPUT_COUNT-1:0] bias_in;
    logic                               weight_rd;
    logic [ADDR_WIDTH-1:0]              weight_addr;
    logic [DATA_WIDTH-1:0]              weight_data;
    logic [DATA_WIDTH*OUTPUT_COUNT-1:0] data_out;
    logic                               busy;
    logic                               done;

    modport master (
        output start, data_in, bias_in, weight_data,
        input  weight_rd, weight_addr, data_out, busy, done
    );

    modport slave (
        input  start, data_in, bias_in, weight_data,
        output weight_rd, weight_addr, data_out, busy, done
    );
endinterface

// File: rtl/vector_dense_layer.sv
// rtl/vector_dense_layer.sv - fixed-point dense layer y = W*x + b with one shared MAC
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   vector_dense_layer_if.slave (start, data_in, bias_in, weight_rd,
//         weight_addr, weight_data, data_out, busy, done)
// Optional build macro VECTOR_DENSE_ROUND_EN: round half toward +inf before
// the output shift instead of truncating. Saturation is the same either way.
module vector_dense_layer #(
    parameter int INPUT_COUNT  = 64,
    parameter int OUTPUT_COUNT = 128,
    parameter int DATA_WIDTH   = 16,
    parameter int Q_FRAC       = 8,
    parameter int ADDR_WIDTH   = 13
) (
    input  logic                clk,
    input  logic                rst,
    vector_dense_layer_if.slave bus
);
    localparam int N  = INPUT_COUNT;
    localparam int M  = OUTPUT_COUNT;
    localparam int DW = DATA_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = 2 * DW;
    // One guard bit per doubling of N plus a sign bit: the sum of N full
    // products can never overflow.
    localparam int AW = PW + $clog2(N) + 1;
    // Headroom for adding the aligned bias and the rounding constant.
    localparam int SW = AW + 2;

    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

    localparam logic signed [SW-1:0] Y_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] Y_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

`ifdef VECTOR_DENSE_ROUND_EN
    // Half an output LSB; zero when there are no fractional bits.
    localparam logic signed [SW-1:0] ROUND = (SW'(1) << Q_FRAC) >> 1;
`else
    localparam logic signed [SW-1:0] ROUND = '0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, LAST, WRITE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q,   row_d;
    logic [CW-1:0]         col_q,   col_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  rd_q,    rd_d;
    logic                  vld_q,   vld_d;
    logic [CW-1:0]         tag_q,   tag_d;
    logic signed [AW-1:0]  acc_q,   acc_d;
    logic [DW*N-1:0]       x_q,     x_d;
    logic [DW*M-1:0]       b_q,     b_d;
    logic [DW*M-1:0]       y_q,     y_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic signed [DW-1:0]  x_sel;
    logic signed [DW-1:0]  w_sel;
    logic signed [DW-1:0]  b_sel;
    logic signed [DW-1:0]  y_sat;
    logic signed [PW-1:0]  product;
    logic signed [SW-1:0]  sum_s;
    logic signed [SW-1:0]  y_full;

    // Datapath: MAC operand selection and output rescale/saturation.
    always_comb begin
        // tag_q names the column whose weight is arriving this cycle.
        x_sel   = x_q[int'(tag_q) * DW +: DW];
        w_sel   = bus.weight_data;
        b_sel   = b_q[int'(row_q) * DW +: DW];
        product = PW'(x_sel) * PW'(w_sel);
        // Bias is Q F; shift it up to the accumulator's Q 2F before adding.
        sum_s   = SW'(acc_q) + (SW'(b_sel) <<< Q_FRAC) + ROUND;
        y_full  = sum_s >>> Q_FRAC;
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[DW-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[DW-1:0];
        end else begin
            y_sat = y_full[DW-1:0];
        end
    end

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        vld_d   = 1'b0;
        tag_d   = col_q;
        acc_d   = acc_q;
        x_d     = x_q;
        b_d     = b_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (vld_q) begin
            acc_d = acc_q + AW'(product);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.data_in;
                    b_d     = bus.bias_in;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The read held in rd_q/addr_q is issued this cycle; tag it
                // so the product lands one cycle later with the right x.
                vld_d = 1'b1;
                tag_d = col_q;
                if (col_q == COL_LAST) begin
                    rd_d    = 1'b0;
                    state_d = LAST;
                end else begin
                    col_d  = col_q + CW'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            LAST: begin
                state_d = WRITE;
            end
            WRITE: begin
                y_d[int'(row_q) * DW +: DW] = y_sat;
                acc_d = '0;
                if (row_q == ROW_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rd_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Row-major addressing makes the next row's first
                    // weight the one right after this row's last.
                    row_d   = row_q + RW'(1);
                    col_d   = '0;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    rd_d    = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
            tag_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            b_q     <= b_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.weight_rd   = rd_q;
    assign bus.weight_addr = addr_q;
    assign bus.data_out    = y_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
